omni_rr_arbiter: RTL
====================

Name: omni_rr_arbiter

Overview:
- Sequential, packet-aware arbiter feeding the shared 512+16-bit collector output.
- Replaces fixed-priority per-beat selection with round-robin at packet granularity among NUM_SLOTS slot ports, plus a loopback port (index NUM_SLOTS).
- Output is registered through a 2-entry skid stage.
- Sits between the per-slot top-k engines / loopback path and the TX stream toward the network stack.

Parameters:
- NUM_SLOTS, 2, number of slot requesters (ports 0..NUM_SLOTS-1); port NUM_SLOTS is loopback.
- WIDTH, 528, beat width (512 payload + 16 metadata).
- IDW, $clog2(NUM_SLOTS+1), width of grant index.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- rx_TDATA  in  (NUM_SLOTS+1)*WIDTH  flattened input beats; port p occupies bits [(p+1)*WIDTH-1 -: WIDTH].
- rx_TVALID  in  NUM_SLOTS+1  per-port valid.
- rx_TLAST  in  NUM_SLOTS+1  per-port end-of-packet.
- rx_TREADY  out  NUM_SLOTS+1  per-port ready; at most one bit high.
- tx_TDATA  out  WIDTH  output beat.
- tx_TVALID  out  1  output valid.
- tx_TLAST  out  1  output end-of-packet.
- tx_TREADY  in  1  downstream ready.
- grant_id  out  IDW  currently locked port; valid when grant_active = 1.
- grant_active  out  1  high while in LOCKED.

Behaviour:
- Reset (rst = 0, async):
  - tx_TVALID = 0, tx_TDATA = 0, tx_TLAST = 0.
  - Skid buffer empty; state = IDLE; rr_ptr = 0.
  - grant_id = 0, grant_active = 0, rx_TREADY = 0.
- FSM states: IDLE, LOCKED.
- IDLE arbitration (combinational):
  - Search slots starting at rr_ptr, wrapping modulo NUM_SLOTS; the first slot with TVALID = 1 wins.
  - Loopback wins only if no slot TVALID is high.
  - If nothing is valid, remain in IDLE and keep rx_TREADY = 0.
- IDLE first beat: the winner's rx_TREADY = !skid_full in the same cycle.
  - Accepted beat with TLAST = 0: go to LOCKED, latch grant_id = winner.
  - Accepted beat with TLAST = 1 (single-beat packet): stay in IDLE.
  - Not accepted (skid full): no lock is taken; re-arbitrate next cycle.
- LOCKED:
  - rx_TREADY[grant_id] = !skid_full; all other ready bits = 0.
  - Other ports' TVALID is ignored until packet end.
  - Accepted beat with TLAST = 1 returns to IDLE on the next edge.
- rr_ptr update: on acceptance of the final (TLAST) beat of a slot packet, rr_ptr = (grant + 1) mod NUM_SLOTS.
  - Loopback packets do not move rr_ptr.
- Output stage (skid buffer):
  - Accepted beats enter the output register when it is empty or being drained (tx_TVALID & tx_TREADY); otherwise they enter the skid register.
  - skid_full = skid register valid.
  - Latency rx-accept to tx_TVALID: 1 cycle.
  - Full throughput: 1 beat/cycle with tx_TREADY held high.
  - tx_TDATA and tx_TLAST are stable while tx_TVALID = 1 and tx_TREADY = 0.
- No combinational path from tx_TREADY to rx_TREADY; ready derives only from registered skid_full.
- Granted-port TVALID dropped mid-packet: stay LOCKED, no bubble-filling from other ports, wait indefinitely.
- A packet is never interleaved with another port's beats on tx.
- Reset mid-packet: lock, skid contents and rr_ptr are discarded; the partial packet downstream is the upstream's responsibility.
- Simultaneous TLAST accept in LOCKED and new requests: the new grant is decided in the next cycle (one IDLE cycle between multi-beat packets of different or same ports).

Decomposition:
- Shared package (top_k_pkg): WIDTH_PAYLOAD = 512, WIDTH_META = 16, beat struct typedef {data, meta}, LOOPBACK_ID function of NUM_SLOTS.
- Sub-module: axis_skid_buffer (WIDTH+1 bits incl. TLAST), reusable elsewhere in the user kernel.
- Arbitration/FSM logic stays in omni_rr_arbiter.

Test Plan:
- Single requester: slot 0 sends 3-beat packet (data 0xA0..0xA2), tx_TREADY = 1.
  - tx shows A0, A1, A2 on cycles 1-3 after first accept; tx_TLAST only on A2; grant_id = 0 throughout.
- Contention: slots 0 and 1 both assert 2-beat packets continuously, rr_ptr = 0.
  - tx order is slot0 pkt, slot1 pkt, slot0 pkt, ...; never two consecutive packets from the same slot.
- Lock hold: slot 0 mid-packet deasserts TVALID for 4 cycles while slot 1 is valid.
  - rx_TREADY[1] stays 0; no slot-1 beat appears until slot 0's TLAST beat leaves.
- Loopback priority: loopback and slot 1 valid together in IDLE.
  - Slot 1 granted first; loopback granted only when slots idle; rr_ptr unchanged after the loopback packet.
- Backpressure: tx_TREADY toggles 1,0,0,1 during a 5-beat packet.
  - No beat lost or duplicated; tx_TDATA stable while stalled; rx_TREADY drops when skid full.
- Async reset asserted mid-packet (beat 2 of 4).
  - tx_TVALID = 0 immediately; grant_active = 0; after release, slot 1 is arbitrated from rr_ptr = 0.

Source files
------------

// File: rtl/omni_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// omni_rr_arbiter_pkg
// Shared definitions for the collector output arbiter:
//   - beat layout (512-bit payload + 16-bit metadata)
//   - arbiter FSM state type
//   - loopback port index helper
// -----------------------------------------------------------------------------
package omni_rr_arbiter_pkg;

    localparam int unsigned WIDTH_PAYLOAD = 512;
    localparam int unsigned WIDTH_META    = 16;

    typedef struct packed {
        logic [WIDTH_PAYLOAD-1:0] data;
        logic [WIDTH_META-1:0]    meta;
    } beat_t;

    localparam int unsigned BEAT_WIDTH = $bits(beat_t);

    typedef enum logic {
        StIdle,
        StLocked
    } arb_state_e;

    // The loopback requester always sits just above the last slot port.
    function automatic int unsigned loopback_id(input int unsigned num_slots);
        return num_slots;
    endfunction

endpackage

// File: rtl/omni_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// omni_rr_arbiter_if
// Bundles the arbiter's streaming signals.
//   rx_*       : NUM_SLOTS+1 flattened AXI-Stream inputs (port p at
//                bits [(p+1)*WIDTH-1 -: WIDTH]), port NUM_SLOTS is loopback
//   tx_*       : single AXI-Stream output toward the network stack
//   grant_id   : currently locked port (valid while grant_active)
// Modports:
//   master : environment side (drives rx beats, consumes tx beats)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface omni_rr_arbiter_if #(
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned WIDTH     = omni_rr_arbiter_pkg::BEAT_WIDTH,
    parameter int unsigned IDW       = $clog2(NUM_SLOTS + 1)
);

    logic [(NUM_SLOTS+1)*WIDTH-1:0] rx_TDATA;
    logic [NUM_SLOTS:0]             rx_TVALID;
    logic [NUM_SLOTS:0]             rx_TLAST;
    logic [NUM_SLOTS:0]             rx_TREADY;

    logic [WIDTH-1:0]               tx_TDATA;
    logic                           tx_TVALID;
    logic                           tx_TLAST;
    logic                           tx_TREADY;

    logic [IDW-1:0]                 grant_id;
    logic                           grant_active;

    modport master (
        output rx_TDATA, rx_TVALID, rx_TLAST, tx_TREADY,
        input  rx_TREADY, tx_TDATA, tx_TVALID, tx_TLAST, grant_id, grant_active
    );

    modport slave (
        input  rx_TDATA, rx_TVALID, rx_TLAST, tx_TREADY,
        output rx_TREADY, tx_TDATA, tx_TVALID, tx_TLAST, grant_id, grant_active
    );

endinterface

// File: rtl/omni_rr_arbiter_skid.sv
// -----------------------------------------------------------------------------
// omni_rr_arbiter_skid
// Generic 2-entry AXI-Stream skid buffer (output register + skid register).
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   in_data_i/valid/ready : upstream handshake; ready depends only on
//                           registered state (no path from out_ready_i)
//   out_data_o/valid/ready: downstream handshake, output fully registered
// -----------------------------------------------------------------------------
module omni_rr_arbiter_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [Width-1:0] out_data_q, out_data_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_fire;
    logic             out_free;

    assign in_ready_o = !skid_valid_q;
    assign in_fire    = in_valid_i && in_ready_o;
    // Output register can take a new beat when empty or being drained.
    assign out_free   = !out_valid_q || out_ready_i;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                // Skid full implies in_ready_o = 0, so no input beat collides.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/omni_rr_arbiter.sv
// -----------------------------------------------------------------------------
// omni_rr_arbiter
// Packet-granular round-robin arbiter feeding the shared collector output.
// Slots 0..NUM_SLOTS-1 are served round-robin starting at rr_ptr; the
// loopback port (index NUM_SLOTS) only wins when no slot is valid. Once a
// multi-beat packet starts, the port is locked until its TLAST beat.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : omni_rr_arbiter_if.slave (rx inputs, tx output, grant status)
// -----------------------------------------------------------------------------
module omni_rr_arbiter
    import omni_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned WIDTH     = BEAT_WIDTH,
    parameter int unsigned IDW       = $clog2(NUM_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    omni_rr_arbiter_if.slave bus
);

    localparam int unsigned    NUM_PORTS = NUM_SLOTS + 1;
    localparam logic [IDW-1:0] LOOPBACK  = IDW'(loopback_id(NUM_SLOTS));

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDW-1:0] cand;
    logic [IDW-1:0] winner;
    logic           any_valid;
    logic [IDW-1:0] sel;
    logic           sel_valid;
    logic           sel_last;
    logic           skid_ready;
    logic           accept;
    logic [NUM_SLOTS:0] rx_ready;
    logic [WIDTH-1:0]   rx_data [NUM_PORTS];
    logic [WIDTH:0]     tx_beat;

    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_unpack
        assign rx_data[p] = bus.rx_TDATA[(p+1)*WIDTH-1 -: WIDTH];
    end

    // Rotating search over slots starting at rr_ptr; loopback as fallback.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % int'(NUM_SLOTS));
            if (!any_valid && bus.rx_TVALID[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
        if (!any_valid && bus.rx_TVALID[LOOPBACK]) begin
            any_valid = 1'b1;
            winner    = LOOPBACK;
        end
    end

    assign sel       = (state_q == StLocked) ? grant_q : winner;
    assign sel_valid = bus.rx_TVALID[sel];
    assign sel_last  = bus.rx_TLAST[sel];
    // rst gating keeps every ready low while reset is asserted.
    assign accept    = rst && sel_valid && skid_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                // Single-beat packets never take the lock.
                if (accept && !sel_last) begin
                    state_d = StLocked;
                    grant_d = sel;
                end
            end
            StLocked: begin
                if (accept && sel_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept && sel_last && (sel != LOOPBACK)) begin
            rr_ptr_d = IDW'((int'(sel) + 1) % int'(NUM_SLOTS));
        end
    end

    // Outputs
    always_comb begin
        rx_ready = '0;
        if (rst && ((state_q == StLocked) || any_valid)) begin
            rx_ready[sel] = skid_ready;
        end
    end

    assign bus.rx_TREADY    = rx_ready;
    assign bus.grant_id     = grant_q;
    assign bus.grant_active = (state_q == StLocked);

    omni_rr_arbiter_skid #(
        .Width(WIDTH + 1)
    ) u_skid (
        .clk_i      (clk),
        .rst_ni     (rst),
        .in_data_i  ({sel_last, rx_data[sel]}),
        .in_valid_i (sel_valid),
        .in_ready_o (skid_ready),
        .out_data_o (tx_beat),
        .out_valid_o(bus.tx_TVALID),
        .out_ready_i(bus.tx_TREADY)
    );

    assign bus.tx_TLAST = tx_beat[WIDTH];
    assign bus.tx_TDATA = tx_beat[WIDTH-1:0];

endmodule
